skinny_subcells_ctrl: RTL

SKINNY_SUBCELLS_CTRL -- requirements
Module: skinny_subcells_ctrl

---
 rtl/skinny_subcells_ctrl_pkg.sv | 25 ++
 rtl/skinny_pipe_tracker.sv | 55 +++++
 rtl/skinny_subcells_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/skinny_subcells_ctrl_pkg.sv
// Shared definitions for the SKINNY-64 masked SubCells controller.
//
// Contents:
//   state_t  - controller FSM states (IDLE, FEED, DRAIN, DONE)
//   NIBBLES  - nibbles per 64-bit state (16)
//   NIBBLE_W - bits per nibble / S-box width (4)
//   SHARES   - number of Boolean shares (3)
//   IDX_W    - width of a nibble index
//   STATE_W  - width of one state share
package skinny_subcells_ctrl_pkg;

    localparam int NIBBLES  = 16;
    localparam int NIBBLE_W = 4;
    localparam int SHARES   = 3;
    localparam int IDX_W    = $clog2(NIBBLES);
    localparam int STATE_W  = NIBBLES * NIBBLE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/skinny_pipe_tracker.sv
// In-flight tracker for nibbles travelling through the external masked S-box.
// A LATENCY-deep shift register of {valid, index}: an entry pushed in the
// cycle a nibble is driven to the S-box pops out in the cycle the S-box
// result for that nibble is present.
//
// Ports:
//   clk       - clock, rising edge
//   rst_i     - synchronous active-high reset (clears valid bits only)
//   in_valid  - a nibble is being driven to the S-box this cycle
//   in_idx    - index of that nibble
//   out_valid - the S-box result for out_idx is present this cycle
//   out_idx   - nibble index the present S-box result belongs to
module skinny_pipe_tracker
    import skinny_subcells_ctrl_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LATENCY-1:0] valid_q;
    logic [IDX_W-1:0]   idx_q [LATENCY];

    // NOTE: clocked state uses non-blocking (<=) so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // NOTE: the index payload is deliberately not reset; it is only consumed
    // when its valid bit is set, and leaving it reset-free keeps it a plain
    // shift register.
    always_ff @(posedge clk) begin
        idx_q[0] <= in_idx;
        for (int i = 1; i < LATENCY; i++) begin
            idx_q[i] <= idx_q[i-1];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/skinny_subcells_ctrl.sv
// SubCells controller for a three-share masked SKINNY-64 datapath.
// Streams the 16 nibbles of each share through an external pipelined masked
// S-box (one nibble per cycle) and writes the results back in place. Feeding
// and capture overlap, so a run takes 1 + 16 + LATENCY cycles from accepted
// start to the done pulse. Shares are never combined.
//
// Ports:
//   clk                  - clock, rising edge
//   rst_i                - synchronous active-high reset, priority over start
//   state_in1..3         - 64-bit input shares, captured on accepted start
//   start                - start request, honoured only in IDLE
//   busy                 - high during FEED and DRAIN
//   done                 - one-cycle pulse, results valid on state_out1..3
//   state_out1..3        - share registers (substituted state after done)
//   sbox_in1..3          - nibble shares to the S-box (zero outside FEED)
//   sbox_out1..3         - nibble shares returned by the S-box
//   sbox_rc              - S-box round-constant input, tied to zero
module skinny_subcells_ctrl
    import skinny_subcells_ctrl_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [STATE_W-1:0]  state_in1,
    input  logic [STATE_W-1:0]  state_in2,
    input  logic [STATE_W-1:0]  state_in3,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [STATE_W-1:0]  state_out1,
    output logic [STATE_W-1:0]  state_out2,
    output logic [STATE_W-1:0]  state_out3,
    output logic [NIBBLE_W-1:0] sbox_in1,
    output logic [NIBBLE_W-1:0] sbox_in2,
    output logic [NIBBLE_W-1:0] sbox_in3,
    input  logic [NIBBLE_W-1:0] sbox_out1,
    input  logic [NIBBLE_W-1:0] sbox_out2,
    input  logic [NIBBLE_W-1:0] sbox_out3,
    output logic [7:0]          sbox_rc
);

    // Drain counter only needs to count 0..LATENCY-1.
    localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0]   NIB_LAST   = IDX_W'(NIBBLES - 1);

    state_t                                 state;
    logic [IDX_W-1:0]                       nib_cnt;
    logic [DRAIN_W-1:0]                     drain_cnt;
    logic [SHARES-1:0][STATE_W-1:0]         share_q;
    logic [SHARES-1:0][NIBBLE_W-1:0]        sbox_in_s;
    logic [SHARES-1:0][NIBBLE_W-1:0]        sbox_out_s;
    logic                                   trk_valid;
    logic [IDX_W-1:0]                       trk_idx;
    logic                                   accept;

    assign accept     = (state == IDLE) && start;
    assign sbox_out_s = {sbox_out3, sbox_out2, sbox_out1};

    skinny_pipe_tracker #(
        .LATENCY (LATENCY)
    ) u_tracker (
        .clk       (clk),
        .rst_i     (rst_i),
        .in_valid  (state == FEED),
        .in_idx    (nib_cnt),
        .out_valid (trk_valid),
        .out_idx   (trk_idx)
    );

    // Controller FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            nib_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= FEED;
                        busy    <= 1'b1;
                        nib_cnt <= '0;
                    end
                end
                FEED: begin
                    nib_cnt <= nib_cnt + 1'b1;
                    if (nib_cnt == NIB_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Share registers: bulk load on accepted start, otherwise in-place
    // nibble write-back of whatever result the tracker says is arriving.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            share_q <= '0;
        end else if (accept) begin
            share_q <= {state_in3, state_in2, state_in1};
        end else if (trk_valid) begin
            for (int s = 0; s < SHARES; s++) begin
                share_q[s][{trk_idx, 2'b00} +: NIBBLE_W] <= sbox_out_s[s];
            end
        end
    end

    // Nibble mux to the S-box; forced to zero outside FEED so no share
    // material reaches the S-box while idle or draining.
    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sbox_in_s = '0;
        if (state == FEED) begin
            for (int s = 0; s < SHARES; s++) begin
                sbox_in_s[s] = share_q[s][{nib_cnt, 2'b00} +: NIBBLE_W];
            end
        end
    end

    assign sbox_in1   = sbox_in_s[0];
    assign sbox_in2   = sbox_in_s[1];
    assign sbox_in3   = sbox_in_s[2];
    assign state_out1 = share_q[0];
    assign state_out2 = share_q[1];
    assign state_out3 = share_q[2];
    assign sbox_rc    = 8'h00;

endmodule
